// File: rtl/scmi_mbox_pkg.sv
// Shared definitions for the SCMI mailbox initiator: shared-memory layout,
// FSM state encoding, error codes and the default register-bus types.
package scmi_mbox_pkg;

    localparam logic [31:0] OFF_CHAN_STATUS = 32'h0000_0004;
    localparam logic [31:0] OFF_FLAGS       = 32'h0000_0010;
    localparam logic [31:0] OFF_LENGTH      = 32'h0000_0014;
    localparam logic [31:0] OFF_HEADER      = 32'h0000_0018;
    localparam logic [31:0] OFF_PAYLOAD     = 32'h0000_001C;

    localparam int unsigned STATUS_FREE_BIT  = 0;
    localparam int unsigned STATUS_ERROR_BIT = 1;

    typedef enum logic [3:0] {
        IDLE, POLL_FREE, WR_FLAGS, WR_LEN, WR_HDR, WR_PLD, SET_BUSY,
        RING, WAIT_IRQ, ACK_IRQ, RD_LEN, RD_HDR, RD_PLD, RESP
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_BUS     = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_TRUNC   = 2'd3
    } err_e;

    typedef struct packed {
        logic [63:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } mbox_reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } mbox_reg_rsp_t;

    function automatic logic [31:0] payload_off(input logic [31:0] idx);
        return OFF_PAYLOAD + (idx << 2);
    endfunction

endpackage

// File: rtl/scmi_mbox_initiator.sv
// SCMI shared-memory mailbox initiator: posts a command into the channel,
// rings the doorbell, waits for completion and reads back the response.
module scmi_mbox_initiator
    import scmi_mbox_pkg::*;
#(
    parameter int unsigned           AddrWidth        = 64,
    parameter logic [AddrWidth-1:0]  BaseAddr         = {AddrWidth{1'b0}},
    parameter logic [31:0]           DoorbellOffset   = 32'h0000_0020,
    parameter logic [31:0]           CompletionOffset = 32'h0000_0024,
    parameter int unsigned           MaxWords         = 8,
    parameter int unsigned           TimeoutCycles    = 65535,
    parameter type                   reg_req_t        = scmi_mbox_pkg::mbox_reg_req_t,
    parameter type                   reg_rsp_t        = scmi_mbox_pkg::mbox_reg_rsp_t,
    localparam int unsigned          LenW             = $clog2(MaxWords + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic [31:0]                 cmd_hdr_i,
    input  logic [LenW-1:0]             cmd_len_i,
    input  logic [MaxWords-1:0][31:0]   cmd_payload_i,
    output reg_req_t                    reg_req_o,
    input  reg_rsp_t                    reg_rsp_i,
    input  logic                        irq_completion_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [31:0]                 rsp_hdr_o,
    output logic [LenW-1:0]             rsp_len_o,
    output logic [MaxWords-1:0][31:0]   rsp_payload_o,
    output logic [1:0]                  rsp_err_o
);

    state_e                     state_r, state_s;
    logic [31:0]                cmd_hdr_r;
    logic [LenW-1:0]            cmd_len_r;
    logic [MaxWords-1:0][31:0]  cmd_pld_r;
    logic                       cmd_take_s;
    logic [LenW-1:0]            idx_r, idx_s;
    logic [31:0]                wait_cnt_r, wait_cnt_s;
    logic [LenW-1:0]            rd_words_r, rd_words_s;
    logic                       trunc_r, trunc_s;
    logic [31:0]                words_raw_s;

    logic                       req_valid_r, req_valid_s;
    logic                       req_write_r, req_write_s;
    logic [AddrWidth-1:0]       req_addr_r, req_addr_s;
    logic [31:0]                req_off_s;
    logic [31:0]                req_wdata_r, req_wdata_s;
    logic [31:0]                pld_word_s;

    logic                       rsp_valid_r;
    logic [31:0]                rsp_hdr_r, rsp_hdr_s;
    logic [LenW-1:0]            rsp_len_r, rsp_len_s;
    logic [MaxWords-1:0][31:0]  rsp_pld_r, rsp_pld_s;
    err_e                       rsp_err_r, rsp_err_s;

    logic                       xfer_s;

    assign xfer_s      = req_valid_r & reg_rsp_i.ready;
    assign words_raw_s = (reg_rsp_i.rdata < 32'd4) ? 32'd0 : ((reg_rsp_i.rdata - 32'd4) >> 2);

    // Next-state, sequencing counters and response datapath.
    always_comb begin
        state_s    = state_r;
        cmd_take_s = 1'b0;
        idx_s      = idx_r;
        wait_cnt_s = wait_cnt_r;
        rd_words_s = rd_words_r;
        trunc_s    = trunc_r;
        rsp_hdr_s  = rsp_hdr_r;
        rsp_len_s  = rsp_len_r;
        rsp_pld_s  = rsp_pld_r;
        rsp_err_s  = rsp_err_r;

        case (state_r)
            IDLE: begin
                if (cmd_valid_i) begin
                    cmd_take_s = 1'b1;
                    state_s    = POLL_FREE;
                    idx_s      = {LenW{1'b0}};
                    wait_cnt_s = 32'd0;
                    rd_words_s = {LenW{1'b0}};
                    trunc_s    = 1'b0;
                    rsp_hdr_s  = 32'd0;
                    rsp_len_s  = {LenW{1'b0}};
                    rsp_pld_s  = {(MaxWords*32){1'b0}};
                    rsp_err_s  = ERR_OK;
                end else begin
                    state_s = IDLE;
                end
            end
            POLL_FREE: state_s = (xfer_s && reg_rsp_i.rdata[STATUS_FREE_BIT]) ? WR_FLAGS : POLL_FREE;
            WR_FLAGS:  state_s = xfer_s ? WR_LEN : WR_FLAGS;
            WR_LEN:    state_s = xfer_s ? WR_HDR : WR_LEN;
            WR_HDR: begin
                if (xfer_s) begin
                    state_s = (cmd_len_r == {LenW{1'b0}}) ? SET_BUSY : WR_PLD;
                    idx_s   = {LenW{1'b0}};
                end else begin
                    state_s = WR_HDR;
                end
            end
            WR_PLD: begin
                if (xfer_s && (idx_r == cmd_len_r - LenW'(1))) begin
                    state_s = SET_BUSY;
                end else if (xfer_s) begin
                    idx_s = idx_r + LenW'(1);
                end else begin
                    state_s = WR_PLD;
                end
            end
            SET_BUSY: state_s = xfer_s ? RING : SET_BUSY;
            RING: begin
                if (xfer_s) begin
                    state_s    = WAIT_IRQ;
                    wait_cnt_s = 32'd0;
                end else begin
                    state_s = RING;
                end
            end
            WAIT_IRQ: begin
                if (irq_completion_i) begin
                    state_s = ACK_IRQ;
                end else if (wait_cnt_r >= 32'(TimeoutCycles) - 32'd1) begin
                    state_s   = RESP;
                    rsp_err_s = ERR_TIMEOUT;
                end else begin
                    wait_cnt_s = wait_cnt_r + 32'd1;
                end
            end
            ACK_IRQ: state_s = xfer_s ? RD_LEN : ACK_IRQ;
            RD_LEN: begin
                if (xfer_s) begin
                    state_s    = RD_HDR;
                    trunc_s    = (words_raw_s > 32'(MaxWords));
                    rd_words_s = trunc_s ? LenW'(MaxWords) : LenW'(words_raw_s);
                end else begin
                    state_s = RD_LEN;
                end
            end
            RD_HDR: begin
                if (xfer_s) begin
                    rsp_hdr_s = reg_rsp_i.rdata;
                    idx_s     = {LenW{1'b0}};
                    state_s   = (rd_words_r == {LenW{1'b0}}) ? RESP : RD_PLD;
                    rsp_err_s = trunc_r ? ERR_TRUNC : ERR_OK;
                end else begin
                    state_s = RD_HDR;
                end
            end
            RD_PLD: begin
                if (xfer_s) begin
                    for (int i = 0; i < int'(MaxWords); i++) begin
                        rsp_pld_s[i] = (idx_r == LenW'(i)) ? reg_rsp_i.rdata : rsp_pld_r[i];
                    end
                    rsp_len_s = rsp_len_r + LenW'(1);
                    idx_s     = idx_r + LenW'(1);
                    state_s   = (idx_r == rd_words_r - LenW'(1)) ? RESP : RD_PLD;
                    rsp_err_s = trunc_r ? ERR_TRUNC : ERR_OK;
                end else begin
                    state_s = RD_PLD;
                end
            end
            RESP:    state_s = rsp_ready_i ? IDLE : RESP;
            default: state_s = IDLE;
        endcase

        // A bus error aborts whatever transaction was in flight and discards its data.
        if (xfer_s && reg_rsp_i.error) begin
            state_s   = RESP;
            rsp_err_s = ERR_BUS;
            rsp_hdr_s = rsp_hdr_r;
            rsp_len_s = rsp_len_r;
            rsp_pld_s = rsp_pld_r;
        end else begin
            rsp_err_s = rsp_err_s;
        end
    end

    // Register-bus request for the state being entered, so outputs come straight from flops.
    always_comb begin
        req_valid_s = 1'b1;
        req_write_s = 1'b0;
        req_off_s   = 32'd0;
        req_wdata_s = 32'd0;
        pld_word_s  = 32'd0;
        for (int i = 0; i < int'(MaxWords); i++) begin
            pld_word_s = (idx_s == LenW'(i)) ? cmd_pld_r[i] : pld_word_s;
        end
        case (state_s)
            POLL_FREE: req_off_s = OFF_CHAN_STATUS;
            WR_FLAGS:  begin req_write_s = 1'b1; req_off_s = OFF_FLAGS;        req_wdata_s = 32'd1; end
            WR_LEN:    begin req_write_s = 1'b1; req_off_s = OFF_LENGTH;       req_wdata_s = (32'(cmd_len_r) + 32'd1) << 2; end
            WR_HDR:    begin req_write_s = 1'b1; req_off_s = OFF_HEADER;       req_wdata_s = cmd_hdr_r; end
            WR_PLD:    begin req_write_s = 1'b1; req_off_s = payload_off(32'(idx_s)); req_wdata_s = pld_word_s; end
            SET_BUSY:  begin req_write_s = 1'b1; req_off_s = OFF_CHAN_STATUS;  req_wdata_s = 32'd0; end
            RING:      begin req_write_s = 1'b1; req_off_s = DoorbellOffset;   req_wdata_s = 32'd1; end
            ACK_IRQ:   begin req_write_s = 1'b1; req_off_s = CompletionOffset; req_wdata_s = 32'd0; end
            RD_LEN:    req_off_s = OFF_LENGTH;
            RD_HDR:    req_off_s = OFF_HEADER;
            RD_PLD:    req_off_s = payload_off(32'(idx_s));
            default:   req_valid_s = 1'b0;
        endcase
        req_addr_s = BaseAddr + AddrWidth'(req_off_s);
    end

    // State, command latch, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= IDLE;
            cmd_hdr_r   <= 32'd0;
            cmd_len_r   <= {LenW{1'b0}};
            cmd_pld_r   <= {(MaxWords*32){1'b0}};
            idx_r       <= {LenW{1'b0}};
            wait_cnt_r  <= 32'd0;
            rd_words_r  <= {LenW{1'b0}};
            trunc_r     <= 1'b0;
            req_valid_r <= 1'b0;
            req_write_r <= 1'b0;
            req_addr_r  <= {AddrWidth{1'b0}};
            req_wdata_r <= 32'd0;
            rsp_valid_r <= 1'b0;
            rsp_hdr_r   <= 32'd0;
            rsp_len_r   <= {LenW{1'b0}};
            rsp_pld_r   <= {(MaxWords*32){1'b0}};
            rsp_err_r   <= ERR_OK;
        end else begin
            state_r     <= state_s;
            if (cmd_take_s) begin
                cmd_hdr_r <= cmd_hdr_i;
                cmd_len_r <= (cmd_len_i > LenW'(MaxWords)) ? LenW'(MaxWords) : cmd_len_i;
                cmd_pld_r <= cmd_payload_i;
            end else begin
                cmd_hdr_r <= cmd_hdr_r;
                cmd_len_r <= cmd_len_r;
                cmd_pld_r <= cmd_pld_r;
            end
            idx_r       <= idx_s;
            wait_cnt_r  <= wait_cnt_s;
            rd_words_r  <= rd_words_s;
            trunc_r     <= trunc_s;
            req_valid_r <= req_valid_s;
            req_write_r <= req_write_s;
            req_addr_r  <= req_addr_s;
            req_wdata_r <= req_wdata_s;
            rsp_valid_r <= (state_s == RESP);
            rsp_hdr_r   <= rsp_hdr_s;
            rsp_len_r   <= rsp_len_s;
            rsp_pld_r   <= rsp_pld_s;
            rsp_err_r   <= rsp_err_s;
        end
    end

    // Drive the register-bus request struct from its flops.
    always_comb begin
        reg_req_o       = '0;
        reg_req_o.valid = req_valid_r;
        reg_req_o.write = req_write_r;
        reg_req_o.addr  = req_addr_r;
        reg_req_o.wdata = req_wdata_r;
        reg_req_o.wstrb = 4'hF;
    end

    assign cmd_ready_o   = (state_r == IDLE);
    assign rsp_valid_o   = rsp_valid_r;
    assign rsp_hdr_o     = rsp_hdr_r;
    assign rsp_len_o     = rsp_len_r;
    assign rsp_payload_o = rsp_pld_r;
    assign rsp_err_o     = rsp_err_r;

endmodule
